// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle sequencer for the Hack CPU: owns A, D, PC and IR, drives an external
// combinational ALU and talks to instruction and data memories over req/ack ports.
module hack_cpu_ctrl #(
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned PC_WIDTH = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [15:0]         imem_addr,
  input  logic                imem_ack,
  input  logic [15:0]         imem_data,
  output logic [15:0]         dmem_addr,
  output logic                dmem_rd,
  output logic                dmem_wr,
  output logic [15:0]         dmem_wdata,
  input  logic                dmem_ack,
  input  logic [15:0]         dmem_rdata,
  output logic [15:0]         alu_x,
  output logic [15:0]         alu_y,
  output logic [5:0]          alu_c,
  input  logic [15:0]         alu_out,
  input  logic                alu_zo,
  input  logic                alu_ng,
  output logic [PC_WIDTH-1:0] pc
);

  localparam logic [PC_WIDTH-1:0] ResetPc = PC_WIDTH'(RESET_PC);

  typedef enum logic [2:0] {StFetch, StDecode, StMread, StExec, StWb} state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic [15:0]         a_q, a_d, d_q, d_d, ir_q, ir_d, m_q, m_d, res_q, res_d;
  logic                zf_q, zf_d, nf_q, nf_d;
  logic                imem_req_q, imem_req_d, dmem_rd_q, dmem_rd_d, dmem_wr_q, dmem_wr_d;
  logic                jmp, commit;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    d_d     = d_q;
    ir_d    = ir_q;
    m_d     = m_q;
    res_d   = res_q;
    zf_d    = zf_q;
    nf_d    = nf_q;
    commit  = 1'b0;
    pc_inc  = pc_q + PC_WIDTH'(1);
    jmp     = (ir_q[2] & nf_q) | (ir_q[1] & zf_q) | (ir_q[0] & ~nf_q & ~zf_q);

    unique case (state_q)
      StFetch: begin
        // imem_req_q is low only in the first cycle after reset release; ignore stray acks
        if (imem_req_q && imem_ack) begin
          ir_d    = imem_data;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (!ir_q[15]) begin
          a_d     = ir_q;
          pc_d    = pc_inc;
          state_d = StFetch;
        end else if (ir_q[12]) begin
          state_d = StMread;
        end else begin
          state_d = StExec;
        end
      end
      StMread: begin
        if (dmem_rd_q && dmem_ack) begin
          m_d     = dmem_rdata;
          state_d = StExec;
        end
      end
      StExec: begin
        res_d   = alu_out;
        zf_d    = alu_zo;
        nf_d    = alu_ng;
        state_d = StWb;
      end
      StWb: begin
        commit = !ir_q[3] || (dmem_wr_q && dmem_ack);
      end
      default: state_d = StFetch;
    endcase

    // Jump target and data address both use A as it was before this commit.
    if (commit) begin
      if (ir_q[5]) a_d = res_q;
      if (ir_q[4]) d_d = res_q;
      pc_d    = jmp ? a_q[PC_WIDTH-1:0] : pc_inc;
      state_d = StFetch;
    end

    imem_req_d = (state_d == StFetch);
    dmem_rd_d  = (state_d == StMread);
    dmem_wr_d  = (state_d == StWb) && ir_q[3];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFetch;
      pc_q       <= ResetPc;
      a_q        <= '0;
      d_q        <= '0;
      ir_q       <= '0;
      m_q        <= '0;
      res_q      <= '0;
      zf_q       <= 1'b0;
      nf_q       <= 1'b0;
      imem_req_q <= 1'b0;
      dmem_rd_q  <= 1'b0;
      dmem_wr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      a_q        <= a_d;
      d_q        <= d_d;
      ir_q       <= ir_d;
      m_q        <= m_d;
      res_q      <= res_d;
      zf_q       <= zf_d;
      nf_q       <= nf_d;
      imem_req_q <= imem_req_d;
      dmem_rd_q  <= dmem_rd_d;
      dmem_wr_q  <= dmem_wr_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = 16'(pc_q);
  assign dmem_addr  = a_q;
  assign dmem_rd    = dmem_rd_q;
  assign dmem_wr    = dmem_wr_q;
  assign dmem_wdata = res_q;
  assign alu_x      = d_q;
  assign alu_y      = ir_q[12] ? m_q : a_q;
  assign alu_c      = {ir_q[6], ir_q[7], ir_q[8], ir_q[10], ir_q[9], ir_q[11]};
  assign pc         = pc_q;

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Bench for hack_cpu_ctrl: directed program table, randomized programs against an
// instruction-level Hack model, and a reset-abort sequence.
module tb_hack_cpu_ctrl;
  localparam int unsigned PcW = 15;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           imem_req;
  logic [15:0]    imem_addr;
  logic           imem_ack = 1'b0;
  logic [15:0]    imem_data = '0;
  logic [15:0]    dmem_addr;
  logic           dmem_rd, dmem_wr;
  logic [15:0]    dmem_wdata;
  logic           dmem_ack = 1'b0;
  logic [15:0]    dmem_rdata = '0;
  logic [15:0]    alu_x, alu_y, alu_out;
  logic [5:0]     alu_c;
  logic           alu_zo, alu_ng;
  logic [PcW-1:0] pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hack_cpu_ctrl #(.RESET_PC(0), .PC_WIDTH(PcW)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .dmem_addr(dmem_addr), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .alu_x(alu_x), .alu_y(alu_y), .alu_c(alu_c), .alu_out(alu_out),
    .alu_zo(alu_zo), .alu_ng(alu_ng), .pc(pc)
  );

  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic zx, input logic nx, input logic zy,
                                           input logic ny, input logic f, input logic no);
    logic [15:0] a, b, o;
    a = zx ? 16'h0 : x;
    if (nx) a = ~a;
    b = zy ? 16'h0 : y;
    if (ny) b = ~b;
    o = f ? a + b : a & b;
    if (no) o = ~o;
    return o;
  endfunction

  // ALU seen through the port bit order {no,f,ny,nx,zy,zx}
  always_comb begin
    alu_out = hack_alu(alu_x, alu_y, alu_c[0], alu_c[2], alu_c[1], alu_c[3], alu_c[4], alu_c[5]);
    alu_zo  = (alu_out == 16'h0);
    alu_ng  = alu_out[15];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [15:0] rom [256];
  logic [15:0] ram [256];
  logic [15:0] mram [256];
  int  imax = 0, dmin = 0, dmax = 0;
  bit  noise = 0;
  int  iwait = 0, dwait = 0;
  bit  ipend = 0, dpend = 0;
  int  fetch_cnt = 0, fetch_limit = 32'h4000_0000;
  int  rd_cnt = 0, wr_cnt = 0, rd_cyc = 0;
  logic [15:0] last_waddr = '0, last_wdata = '0;
  logic [PcW-1:0] snap_pc [$];
  logic [15:0]    snap_a [$], snap_d [$];
  logic [5:0]     snap_c [$];

  // Instruction-level reference model
  bit             model_en = 0, mhave = 0;
  logic [15:0]    ma = '0, md = '0, mpend = '0;
  logic [PcW-1:0] mpc = '0;

  task automatic model_exec(input logic [15:0] w);
    logic [15:0] y, o;
    logic        j;
    if (!w[15]) begin
      ma  = w;
      mpc = mpc + 15'd1;
    end else begin
      y = w[12] ? mram[ma[7:0]] : ma;
      o = hack_alu(md, y, w[11], w[10], w[9], w[8], w[7], w[6]);
      if (w[3]) mram[ma[7:0]] = o;
      j = (w[2] && o[15]) || (w[1] && o == 16'h0) || (w[0] && !o[15] && o != 16'h0);
      if (w[4]) md = o;
      mpc = j ? ma[PcW-1:0] : mpc + 15'd1;
      if (w[5]) ma = o;
    end
  endtask

  // Memory responders plus per-fetch snapshots and model comparison
  always @(negedge clk) begin
    if (!rst_n) begin
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      ipend    = 0;
      dpend    = 0;
    end else begin
      check("rd_wr_exclusive", {31'b0, dmem_rd & dmem_wr}, 32'd0);
      if (!imem_req) begin
        ipend    = 0;
        imem_ack = noise && ($urandom_range(0, 3) == 0);
      end else begin
        if (!ipend) begin
          ipend = 1;
          iwait = $urandom_range(0, imax);
        end
        if (iwait > 0) begin
          imem_ack = 1'b0;
          iwait--;
        end else if (fetch_cnt >= fetch_limit) begin
          imem_ack = 1'b0;
        end else begin
          imem_ack  = 1'b1;
          imem_data = rom[imem_addr[7:0]];
          fetch_cnt++;
          snap_pc.push_back(pc);
          snap_a.push_back(dmem_addr);
          snap_d.push_back(alu_x);
          snap_c.push_back(alu_c);
          if (model_en) begin
            if (mhave) model_exec(mpend);
            check("model_pc", {17'b0, pc}, {17'b0, mpc});
            check("model_imem_addr", {16'b0, imem_addr}, {17'b0, mpc});
            check("model_A", {16'b0, dmem_addr}, {16'b0, ma});
            check("model_D", {16'b0, alu_x}, {16'b0, md});
            mpend = rom[mpc[7:0]];
            mhave = 1;
          end
        end
      end
      if (!(dmem_rd || dmem_wr)) begin
        dpend      = 0;
        dmem_ack   = noise && ($urandom_range(0, 3) == 0);
        dmem_rdata = 16'($urandom);
      end else begin
        if (dmem_rd) rd_cyc++;
        if (!dpend) begin
          dpend = 1;
          dwait = $urandom_range(dmin, dmax);
        end
        if (dwait > 0) begin
          dmem_ack = 1'b0;
          dwait--;
        end else begin
          dmem_ack = 1'b1;
          if (dmem_rd) begin
            dmem_rdata = ram[dmem_addr[7:0]];
            rd_cnt++;
          end
          if (dmem_wr) begin
            ram[dmem_addr[7:0]] = dmem_wdata;
            wr_cnt++;
            last_waddr = dmem_addr;
            last_wdata = dmem_wdata;
          end
        end
      end
    end
  end

  task automatic do_reset(input bit chk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    fetch_cnt = 0; rd_cnt = 0; wr_cnt = 0; rd_cyc = 0;
    last_waddr = '0; last_wdata = '0;
    snap_pc.delete(); snap_a.delete(); snap_d.delete(); snap_c.delete();
    mhave = 0; ma = '0; md = '0; mpc = '0;
    repeat (2) @(negedge clk);
    if (chk) begin
      check("rst_imem_req", {31'b0, imem_req}, 32'd0);
      check("rst_dmem_rd", {31'b0, dmem_rd}, 32'd0);
      check("rst_dmem_wr", {31'b0, dmem_wr}, 32'd0);
      check("rst_alu_c", {26'b0, alu_c}, 32'd0);
      check("rst_pc", {17'b0, pc}, 32'd0);
      check("rst_A", {16'b0, dmem_addr}, 32'd0);
      check("rst_D", {16'b0, alu_x}, 32'd0);
    end
    rst_n = 1'b1;
    if (chk) begin
      #1 check("release_req_low", {31'b0, imem_req}, 32'd0);
      @(negedge clk);
      check("release_req_high", {31'b0, imem_req}, 32'd1);
    end
  endtask

  typedef struct {
    logic [15:0] w0, w1, w2, w3;
    int          n;
    logic [7:0]  maddr;
    logic [15:0] mval, ea, ed;
    logic [14:0] epc;
    logic [5:0]  ec;
    int          erd, ewr;
    logic [15:0] ewa, ewd;
    int          ercyc;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] w3, input int n,
                              input logic [7:0] maddr, input logic [15:0] mval,
                              input logic [15:0] ea, input logic [15:0] ed,
                              input logic [14:0] epc, input logic [5:0] ec, input int erd,
                              input int ewr, input logic [15:0] ewa, input logic [15:0] ewd,
                              input int ercyc);
    vec_t v;
    v.w0 = w0; v.w1 = w1; v.w2 = w2; v.w3 = w3; v.n = n; v.maddr = maddr; v.mval = mval;
    v.ea = ea; v.ed = ed; v.epc = epc; v.ec = ec; v.erd = erd; v.ewr = ewr;
    v.ewa = ewa; v.ewd = ewd; v.ercyc = ercyc;
    return v;
  endfunction

  function automatic logic [15:0] gen_instr();
    logic [15:0] w;
    if ($urandom_range(0, 40) == 0) w = 16'h7FFF;
    else if ($urandom_range(0, 2) == 0) w = 16'($urandom_range(0, 255));
    else begin
      w     = 16'($urandom);
      w[15] = 1'b1;
    end
    return w;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs [8];
    bit   ok;
    int   diffs;
    // Final state is the snapshot taken when fetch n (0-based) is accepted.
    vecs[0] = mk(16'h0005, 0, 0, 0, 1, 0, 0, 16'd5, 16'd0, 15'd1, 6'b000000, 0, 0, 0, 0, 0);
    vecs[1] = mk(16'h0005, 16'hEC10, 0, 0, 2, 0, 0, 16'd5, 16'd5, 15'd2, 6'b000101,
                 0, 0, 0, 0, 0);
    vecs[2] = mk(16'h0007, 16'hFDD0, 0, 0, 2, 8'd7, 16'd3, 16'd7, 16'd4, 15'd2, 6'b111101,
                 1, 0, 0, 0, 4);
    vecs[3] = mk(16'h0005, 16'hEC10, 16'h0064, 16'hE3A8, 4, 0, 0, 16'd4, 16'd5, 15'd4,
                 6'b011010, 0, 1, 16'd100, 16'd4, 0);
    vecs[4] = mk(16'h0000, 16'hEC10, 16'h0014, 16'hE302, 4, 0, 0, 16'd20, 16'd0, 15'd20,
                 6'b001010, 0, 0, 0, 0, 0);
    vecs[5] = mk(16'hEE90, 16'h0014, 16'hE304, 0, 3, 0, 0, 16'd20, 16'hFFFF, 15'd20,
                 6'b001010, 0, 0, 0, 0, 0);
    vecs[6] = mk(16'hEE90, 16'h0014, 16'hE301, 0, 3, 0, 0, 16'd20, 16'hFFFF, 15'd3,
                 6'b001010, 0, 0, 0, 0, 0);
    vecs[7] = mk(16'h7FFF, 16'hEA87, 0, 0, 3, 0, 0, 16'd9, 16'd0, 15'd0, 6'b000000,
                 0, 0, 0, 0, 0);

    imax = 0; dmin = 3; dmax = 3; noise = 0;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 256; i++) begin
        rom[i] = 16'h0;
        ram[i] = 16'h0;
      end
      rom[255] = 16'h0009;
      rom[0] = vecs[t].w0; rom[1] = vecs[t].w1; rom[2] = vecs[t].w2; rom[3] = vecs[t].w3;
      ram[vecs[t].maddr] = vecs[t].mval;
      do_reset(t == 0);
      for (int c = 0; c < 300; c++) begin
        if (fetch_cnt > vecs[t].n) break;
        @(posedge clk);
      end
      if (fetch_cnt <= vecs[t].n) begin
        check("vec_timeout", fetch_cnt, vecs[t].n + 1);
      end else begin
        check($sformatf("vec%0d_pc", t), {17'b0, snap_pc[vecs[t].n]}, {17'b0, vecs[t].epc});
        check($sformatf("vec%0d_A", t), {16'b0, snap_a[vecs[t].n]}, {16'b0, vecs[t].ea});
        check($sformatf("vec%0d_D", t), {16'b0, snap_d[vecs[t].n]}, {16'b0, vecs[t].ed});
        check($sformatf("vec%0d_alu_c", t), {26'b0, snap_c[vecs[t].n]}, {26'b0, vecs[t].ec});
        check($sformatf("vec%0d_rd_cnt", t), rd_cnt, vecs[t].erd);
        check($sformatf("vec%0d_wr_cnt", t), wr_cnt, vecs[t].ewr);
        check($sformatf("vec%0d_waddr", t), {16'b0, last_waddr}, {16'b0, vecs[t].ewa});
        check($sformatf("vec%0d_wdata", t), {16'b0, last_wdata}, {16'b0, vecs[t].ewd});
        check($sformatf("vec%0d_rd_cycles", t), rd_cyc, vecs[t].ercyc);
      end
    end

    // Randomized programs with random wait states and stray acks
    for (int i = 0; i < 256; i++) begin
      rom[i]  = gen_instr();
      ram[i]  = 16'($urandom);
      mram[i] = ram[i];
    end
    imax = 2; dmin = 0; dmax = 3; noise = 1;
    fetch_limit = 400;
    model_en = 1;
    do_reset(0);
    for (int c = 0; c < 20000; c++) begin
      if (fetch_cnt >= fetch_limit) break;
      @(posedge clk);
    end
    check("rand_fetch_count", fetch_cnt, fetch_limit);
    repeat (30) @(negedge clk);
    model_en = 0;
    if (mhave) model_exec(mpend);
    check("rand_final_pc", {17'b0, pc}, {17'b0, mpc});
    check("rand_final_A", {16'b0, dmem_addr}, {16'b0, ma});
    check("rand_final_D", {16'b0, alu_x}, {16'b0, md});
    diffs = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== mram[i]) diffs++;
    check("rand_ram_contents", diffs, 0);
    fetch_limit = 32'h4000_0000;

    // Reset asserted while a data read is waiting for its ack
    for (int i = 0; i < 256; i++) begin
      rom[i] = 16'h0;
      ram[i] = 16'h0;
    end
    rom[0] = 16'h0007;
    rom[1] = 16'hFC10;
    ram[7] = 16'h1234;
    imax = 0; dmin = 20; dmax = 20; noise = 0;
    do_reset(0);
    ok = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (dmem_rd) begin
        ok = 1;
        break;
      end
    end
    check("abort_rd_seen", {31'b0, ok}, 32'd1);
    repeat (2) @(negedge clk);
    check("abort_pc_before", {17'b0, pc}, 32'd1);
    check("abort_A_before", {16'b0, dmem_addr}, 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check("abort_rd_drop", {31'b0, dmem_rd}, 32'd0);
    check("abort_imem_req", {31'b0, imem_req}, 32'd0);
    check("abort_pc", {17'b0, pc}, 32'd0);
    check("abort_A", {16'b0, dmem_addr}, 32'd0);
    check("abort_D", {16'b0, alu_x}, 32'd0);
    check("abort_alu_c", {26'b0, alu_c}, 32'd0);
    check("abort_no_read", rd_cnt, 0);
    repeat (2) @(negedge clk);
    check("abort_rd_held_low", {31'b0, dmem_rd}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
